// File: rtl/project_pwm_peripheral_timebase_if.sv
`default_nettype none
// ============================================================================
// Module   : project_pwm_peripheral_timebase_if
// Brief    : Register-file and comparator-side signals of the PWM time base.
// Revision : 1.0 - initial release
// ============================================================================
interface project_pwm_peripheral_timebase_if #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
);
  logic                 i_enable;
  logic [1:0]           i_mode;
  logic [WIDTH-1:0]     i_period;
  logic [PSC_WIDTH-1:0] i_prescale;
  logic                 i_sync_in;
  logic [WIDTH-1:0]     i_phase;
  logic [WIDTH-1:0]     o_counter;
  logic [WIDTH-1:0]     o_counter_next;
  logic [WIDTH-1:0]     o_period;
  logic                 o_dir;
  logic                 o_tick;
  logic                 o_zero;
  logic                 o_period_match;

  modport master (
    output i_enable, i_mode, i_period, i_prescale, i_sync_in, i_phase,
    input  o_counter, o_counter_next, o_period, o_dir, o_tick, o_zero, o_period_match
  );

  modport slave (
    input  i_enable, i_mode, i_period, i_prescale, i_sync_in, i_phase,
    output o_counter, o_counter_next, o_period, o_dir, o_tick, o_zero, o_period_match
  );
endinterface
`default_nettype wire

// File: rtl/project_pwm_peripheral_timebase.sv
`default_nettype none
// ============================================================================
// Module   : project_pwm_peripheral_timebase
// Brief    : Up/down/up-down PWM time base with prescaler, phase sync and
//            period-boundary shadowing of mode, period and prescale.
// Revision : 1.0 - initial release
// ============================================================================
module project_pwm_peripheral_timebase #(
  parameter int WIDTH     = 16,
  parameter int PSC_WIDTH = 8
) (
  input  wire logic                        i_clk,
  input  wire logic                        i_reset_n,
  project_pwm_peripheral_timebase_if.slave bus
);

  localparam logic [1:0]           c_MODE_DOWN   = 2'b01;
  localparam logic [1:0]           c_MODE_UPDOWN = 2'b10;
  localparam logic [WIDTH-1:0]     c_ONE         = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PSC_WIDTH-1:0] c_PSC_ONE     = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0]     r_cnt;
  logic                 r_dir;
  logic [PSC_WIDTH-1:0] r_psc_cnt;
  logic [1:0]           r_mode;
  logic [WIDTH-1:0]     r_period;
  logic [PSC_WIDTH-1:0] r_psc;
  logic                 r_zero;
  logic                 r_match;

  logic                 w_en;
  logic                 w_act_down;
  logic                 w_act_ud;
  logic                 w_in_down;
  logic [WIDTH-1:0]     w_start;
  logic                 w_tick;
  logic                 w_sync;
  logic                 w_adv;
  logic [WIDTH-1:0]     w_phase_clip;
  logic                 w_cnt_at_p;
  logic                 w_cnt_at_0;
  logic                 w_boundary;
  logic [WIDTH-1:0]     w_step;
  logic                 w_step_dir;
  logic [WIDTH-1:0]     w_next;
  logic                 w_load;
  logic [WIDTH-1:0]     w_period_next;
  logic                 w_event;

  assign w_en         = bus.i_enable;
  assign w_act_down   = (r_mode == c_MODE_DOWN);
  assign w_act_ud     = (r_mode == c_MODE_UPDOWN);
  assign w_in_down    = (bus.i_mode == c_MODE_DOWN);
  assign w_start      = w_in_down ? bus.i_period : '0;
  assign w_tick       = w_en && (r_psc_cnt == r_psc);
  assign w_sync       = w_en && bus.i_sync_in;
  assign w_adv        = w_tick && !w_sync;
  assign w_phase_clip = (bus.i_phase > r_period) ? r_period : bus.i_phase;
  assign w_cnt_at_p   = (r_cnt == r_period);
  assign w_cnt_at_0   = (r_cnt == '0);

  // Step on a tick. A zero period pins the counter and makes every tick a boundary.
  always_comb begin
    w_boundary = 1'b0;
    w_step     = r_cnt;
    w_step_dir = r_dir;
    if (r_period == '0) begin
      w_boundary = 1'b1;
      w_step     = '0;
    end else if (w_act_down) begin
      if (w_cnt_at_0) begin
        w_boundary = 1'b1;
        w_step     = bus.i_period;
      end else begin
        w_step = r_cnt - c_ONE;
      end
    end else if (w_act_ud) begin
      if (r_dir) begin
        w_step = w_cnt_at_p ? (r_cnt - c_ONE) : (r_cnt + c_ONE);
        if (w_cnt_at_p) begin
          w_step_dir = 1'b0;
        end
      end else if (w_cnt_at_0) begin
        w_boundary = 1'b1;
        if (bus.i_period != '0) begin
          w_step     = c_ONE;
          w_step_dir = 1'b1;
        end
      end else begin
        w_step = r_cnt - c_ONE;
      end
    end else begin
      if (w_cnt_at_p) begin
        w_boundary = 1'b1;
        w_step     = '0;
      end else begin
        w_step = r_cnt + c_ONE;
      end
    end
  end

  always_comb begin
    w_next = r_cnt;
    if (!w_en) begin
      w_next = w_start;
    end else if (w_sync) begin
      w_next = w_phase_clip;
    end else if (w_tick) begin
      w_next = w_step;
    end
  end

  assign w_load        = w_adv && w_boundary;
  assign w_period_next = (!w_en || w_load) ? bus.i_period : r_period;
  assign w_event       = w_tick || w_sync;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt     <= '0;
      r_dir     <= 1'b1;
      r_psc_cnt <= '0;
      r_mode    <= 2'b00;
      r_period  <= '0;
      r_psc     <= '0;
      r_zero    <= 1'b0;
      r_match   <= 1'b0;
    end else begin
      r_cnt   <= w_next;
      r_zero  <= w_event && (w_next == '0);
      r_match <= w_event && (w_next == w_period_next);
      if (!w_en) begin
        r_mode    <= bus.i_mode;
        r_period  <= bus.i_period;
        r_psc     <= bus.i_prescale;
        r_psc_cnt <= '0;
        r_dir     <= !w_in_down;
      end else if (w_sync) begin
        r_psc_cnt <= '0;
        if (w_act_ud) begin
          r_dir <= 1'b1;
        end
      end else if (w_tick) begin
        r_psc_cnt <= '0;
        r_dir     <= w_step_dir;
        if (w_boundary) begin
          r_mode   <= bus.i_mode;
          r_period <= bus.i_period;
          r_psc    <= bus.i_prescale;
        end
      end else begin
        r_psc_cnt <= r_psc_cnt + c_PSC_ONE;
      end
    end
  end

  // Combinational outputs read as idle while reset is held.
  assign bus.o_counter_next = i_reset_n ? w_next : '0;
  assign bus.o_tick         = i_reset_n && w_adv;
  assign bus.o_counter      = r_cnt;
  assign bus.o_period       = r_period;
  assign bus.o_dir          = r_dir;
  assign bus.o_zero         = r_zero;
  assign bus.o_period_match = r_match;

endmodule
`default_nettype wire

// File: tb/tb_project_pwm_peripheral_timebase.sv
`default_nettype none
// ============================================================================
// Module   : tb_project_pwm_peripheral_timebase
// Brief    : Directed vectors with a queued scoreboard for the PWM time base.
// Revision : 1.0 - initial release
// ============================================================================
module tb_project_pwm_peripheral_timebase;

  typedef struct {
    int          cyc;
    logic [15:0] cnt;
    logic [15:0] nxt;
    logic [15:0] per;
    logic        dir;
    logic        tick;
    logic        zero;
    logic        match;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc_cnt;
  int   total;
  int   bad;
  exp_t q[$];

  project_pwm_peripheral_timebase_if #(.WIDTH(16), .PSC_WIDTH(8)) bus ();

  project_pwm_peripheral_timebase #(.WIDTH(16), .PSC_WIDTH(8)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input int cyc, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  // Inputs for one cycle plus the outputs expected just before the next edge.
  task automatic v(input logic rst, input logic en, input logic [1:0] md,
                   input logic [15:0] per, input logic [7:0] ps, input logic sy,
                   input logic [15:0] ph, input logic [15:0] ecnt, input logic [15:0] enxt,
                   input logic [15:0] eper, input logic edir, input logic etick,
                   input logic ezero, input logic ematch);
    exp_t e;
    @(negedge clk);
    rst_n          = rst;
    bus.i_enable   = en;
    bus.i_mode     = md;
    bus.i_period   = per;
    bus.i_prescale = ps;
    bus.i_sync_in  = sy;
    bus.i_phase    = ph;
    e.cyc   = cyc_cnt;
    e.cnt   = ecnt;
    e.nxt   = enxt;
    e.per   = eper;
    e.dir   = edir;
    e.tick  = etick;
    e.zero  = ezero;
    e.match = ematch;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      while (q.size() > 0 && q[0].cyc == cyc_cnt) begin
        e = q.pop_front();
        chk("counter",      e.cyc, bus.o_counter,             e.cnt);
        chk("counter_next", e.cyc, bus.o_counter_next,        e.nxt);
        chk("period",       e.cyc, bus.o_period,              e.per);
        chk("dir",          e.cyc, 16'(bus.o_dir),            16'(e.dir));
        chk("tick",         e.cyc, 16'(bus.o_tick),           16'(e.tick));
        chk("zero",         e.cyc, 16'(bus.o_zero),           16'(e.zero));
        chk("period_match", e.cyc, 16'(bus.o_period_match),   16'(e.match));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.i_enable = 1'b0; bus.i_mode = 2'b00; bus.i_period = '0;
    bus.i_prescale = '0; bus.i_sync_in = 1'b0; bus.i_phase = '0;
    //  rst en md per ps sy ph   cnt nxt per dir tk z  m
    v(0, 0, 0, 0, 0, 0, 0,       0,  0,  0,  1,  0, 0, 0);
    v(0, 0, 0, 0, 0, 0, 0,       0,  0,  0,  1,  0, 0, 0);
    // UP, P=3, prescale 0
    v(1, 0, 0, 3, 0, 0, 0,       0,  0,  0,  1,  0, 0, 0);
    v(1, 1, 0, 3, 0, 0, 0,       0,  1,  3,  1,  1, 0, 0);
    v(1, 1, 0, 3, 0, 0, 0,       1,  2,  3,  1,  1, 0, 0);
    v(1, 1, 0, 3, 0, 0, 0,       2,  3,  3,  1,  1, 0, 0);
    v(1, 1, 0, 3, 0, 0, 0,       3,  0,  3,  1,  1, 0, 1);
    v(1, 1, 0, 3, 0, 0, 0,       0,  1,  3,  1,  1, 1, 0);
    v(1, 1, 0, 3, 0, 0, 0,       1,  2,  3,  1,  1, 0, 0);
    // stop, then DOWN, P=4, prescale 1
    v(1, 0, 1, 4, 1, 0, 0,       2,  4,  3,  1,  0, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       4,  4,  4,  0,  0, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       4,  3,  4,  0,  1, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       3,  3,  4,  0,  0, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       3,  2,  4,  0,  1, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       2,  2,  4,  0,  0, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       2,  1,  4,  0,  1, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       1,  1,  4,  0,  0, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       1,  0,  4,  0,  1, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       0,  0,  4,  0,  0, 1, 0);
    v(1, 1, 1, 4, 1, 0, 0,       0,  4,  4,  0,  1, 0, 0);
    v(1, 1, 1, 4, 1, 0, 0,       4,  4,  4,  0,  0, 0, 1);
    // UPDOWN, P=2
    v(1, 0, 2, 2, 0, 0, 0,       4,  0,  4,  0,  0, 0, 0);
    v(1, 1, 2, 2, 0, 0, 0,       0,  1,  2,  1,  1, 0, 0);
    v(1, 1, 2, 2, 0, 0, 0,       1,  2,  2,  1,  1, 0, 0);
    v(1, 1, 2, 2, 0, 0, 0,       2,  1,  2,  1,  1, 0, 1);
    v(1, 1, 2, 2, 0, 0, 0,       1,  0,  2,  0,  1, 0, 0);
    v(1, 1, 2, 2, 0, 0, 0,       0,  1,  2,  0,  1, 1, 0);
    v(1, 1, 2, 2, 0, 0, 0,       1,  2,  2,  1,  1, 0, 0);
    v(1, 1, 2, 2, 0, 0, 0,       2,  1,  2,  1,  1, 0, 1);
    // UP, P=5, period rewritten to 2 mid-period
    v(1, 0, 0, 5, 0, 0, 0,       1,  0,  2,  0,  0, 0, 0);
    v(1, 1, 0, 5, 0, 0, 0,       0,  1,  5,  1,  1, 0, 0);
    v(1, 1, 0, 2, 0, 0, 0,       1,  2,  5,  1,  1, 0, 0);
    v(1, 1, 0, 2, 0, 0, 0,       2,  3,  5,  1,  1, 0, 0);
    v(1, 1, 0, 2, 0, 0, 0,       3,  4,  5,  1,  1, 0, 0);
    v(1, 1, 0, 2, 0, 0, 0,       4,  5,  5,  1,  1, 0, 0);
    v(1, 1, 0, 2, 0, 0, 0,       5,  0,  5,  1,  1, 0, 1);
    v(1, 1, 0, 2, 0, 0, 0,       0,  1,  2,  1,  1, 1, 0);
    v(1, 1, 0, 2, 0, 0, 0,       1,  2,  2,  1,  1, 0, 0);
    v(1, 1, 0, 2, 0, 0, 0,       2,  0,  2,  1,  1, 0, 1);
    v(1, 1, 0, 2, 0, 0, 0,       0,  1,  2,  1,  1, 1, 0);
    // sync with phase 7 clipped to P=5, prescale 2; then async reset mid-count
    v(1, 0, 0, 5, 2, 0, 0,       1,  0,  2,  1,  0, 0, 0);
    v(1, 1, 0, 5, 2, 0, 0,       0,  0,  5,  1,  0, 0, 0);
    v(1, 1, 0, 5, 2, 1, 7,       0,  5,  5,  1,  0, 0, 0);
    v(1, 1, 0, 5, 2, 0, 7,       5,  5,  5,  1,  0, 0, 1);
    v(1, 1, 0, 5, 2, 0, 7,       5,  5,  5,  1,  0, 0, 0);
    v(0, 1, 0, 5, 2, 0, 7,       0,  0,  0,  1,  0, 0, 0);
    // P=0, UP, prescale 0
    v(1, 0, 0, 0, 0, 0, 0,       0,  0,  0,  1,  0, 0, 0);
    v(1, 1, 0, 0, 0, 0, 0,       0,  0,  0,  1,  1, 0, 0);
    v(1, 1, 0, 0, 0, 0, 0,       0,  0,  0,  1,  1, 1, 1);
    v(1, 1, 0, 0, 0, 0, 0,       0,  0,  0,  1,  1, 1, 1);
    repeat (3) @(negedge clk);
    #6;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain cyc=%0d got=%0d want=0", cyc_cnt, q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
